// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: drives the ROM fetch address, captures the returned word
// and buffers {pc, inst} pairs so downstream stalls never drop a fetched instruction.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       branch_flag_i,
  input  logic [31:0]                branch_target_i,
  input  logic                       flush_i,
  input  logic [31:0]                new_pc_i,
  output logic                       rom_ce_o,
  output logic [31:0]                rom_addr_o,
  input  logic [31:0]                rom_inst_i,
  output logic [31:0]                if_pc_o,
  output logic [31:0]                if_inst_o,
  output logic                       if_valid_o,
  output logic [$clog2(DEPTH):0]     queue_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic          rom_ce;
  logic          pop, push, redirect;
  logic [31:0]   redirect_pc;

  assign if_valid_o    = (count != '0);
  assign pop           = if_valid_o & ~stall_i;
  assign redirect      = flush_i | branch_flag_i;
  assign push          = rom_ce & ((count < FULL) | pop) & ~redirect;
  // flush outranks branch when both arrive together
  assign redirect_pc   = flush_i ? {new_pc_i[31:2], 2'b00} : {branch_target_i[31:2], 2'b00};

  assign rom_ce_o      = rom_ce;
  assign rom_addr_o    = fetch_pc;
  assign queue_count_o = count;
  assign if_pc_o       = if_valid_o ? pc_mem[head]   : 32'h0;
  assign if_inst_o     = if_valid_o ? inst_mem[head] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rom_ce   <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      rom_ce <= 1'b1;
      if (redirect) begin
        // the popped head is still seen by the consumer this cycle; storage is just dropped
        head  <= '0;
        tail  <= '0;
        count <= '0;
        if (rom_ce) fetch_pc <= redirect_pc;
      end else begin
        if (push) begin
          pc_mem[tail]   <= fetch_pc;
          inst_mem[tail] <= rom_inst_i;
          tail           <= tail + PTR_ONE;
          fetch_pc       <= fetch_pc + 32'd4;
        end
        if (pop) head <= head + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a behavioural model pushes expected {pc, inst}
// pairs and the DUT head, count and ROM interface are compared every cycle.
module tb_if_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_i, branch_flag_i, flush_i;
  logic [31:0] branch_target_i, new_pc_i;
  logic        rom_ce_o, if_valid_o;
  logic [31:0] rom_addr_o, rom_inst_i, if_pc_o, if_inst_o;
  logic [2:0]  queue_count_o;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .flush_i(flush_i), .new_pc_i(new_pc_i),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_inst_i(rom_inst_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_valid_o(if_valid_o),
    .queue_count_o(queue_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  int checks = 0;
  int failures = 0;
  logic        m_ce;
  logic [31:0] m_pc;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // one clock: drive inputs, compare outputs mid-cycle, advance model at the edge
  task automatic cycle(input logic s, input logic b, input logic [31:0] bt,
                       input logic f, input logic [31:0] np, input logic r);
    logic pop, push;
    rst = r; stall_i = s; branch_flag_i = b; branch_target_i = bt;
    flush_i = f; new_pc_i = np;
    #1;
    check("rom_ce", 64'(rom_ce_o), 64'(m_ce));
    check("rom_addr", 64'(rom_addr_o), 64'(m_pc));
    check("count", 64'(queue_count_o), 64'(sb.size()));
    check("valid", 64'(if_valid_o), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_pc", 64'(if_pc_o), 64'(sb[0][63:32]));
      check("head_inst", 64'(if_inst_o), 64'(sb[0][31:0]));
    end else begin
      check("empty_pc", 64'(if_pc_o), 64'h0);
      check("empty_inst", 64'(if_inst_o), 64'h0);
    end
    pop  = (sb.size() != 0) && !s;
    push = m_ce && ((sb.size() < DEPTH) || pop) && !b && !f;
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_ce = 1'b0; sb.delete();
    end else begin
      if (f || b) begin
        sb.delete();
        if (m_ce) m_pc = f ? (np & ~32'h3) : (bt & ~32'h3);
      end else begin
        if (pop) void'(sb.pop_front());
        if (push) begin
          sb.push_back({m_pc, rom_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
      m_ce = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic s, input int n);
    for (int i = 0; i < n; i++) cycle(s, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0;
    branch_target_i = 32'h0; new_pc_i = 32'h0;
    m_ce = 1'b0; m_pc = RESET_PC;
    @(posedge clk); @(negedge clk);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // reset release with stall held: fills to DEPTH and parks
    idle(1'b1, 7);
    check("plan_full_count", 64'(queue_count_o), 64'd4);
    check("plan_full_addr", 64'(rom_addr_o), 64'h10);
    check("plan_full_head", 64'(if_pc_o), 64'h0);

    // full queue, one accepting cycle
    idle(1'b0, 1);
    check("plan_full_pop_addr", 64'(rom_addr_o), 64'h14);
    check("plan_full_pop_head", 64'(if_pc_o), 64'h4);
    idle(1'b1, 1);

    // fresh reset then streaming
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 10);

    // build count=3, then branch to 0x103
    idle(1'b1, 2);
    check("plan_pre_branch_count", 64'(queue_count_o), 64'd3);
    cycle(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0);
    check("plan_branch_addr", 64'(rom_addr_o), 64'h100);
    idle(1'b0, 1);
    check("plan_branch_head", 64'(if_pc_o), 64'h100);
    idle(1'b0, 3);

    // flush beats branch; popped head also redirected
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0020, 1'b0);
    check("plan_flush_addr", 64'(rom_addr_o), 64'h20);
    idle(1'b0, 3);

    // PC wrap at top of address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 2);
    check("plan_wrap_addr", 64'(rom_addr_o), 64'h0);
    idle(1'b1, 2);

    // reset mid-operation with count=3 and a concurrent redirect
    check("plan_pre_rst_count", 64'(queue_count_o), 64'd3);
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0, 1'b1);
    check("plan_rst_ce", 64'(rom_ce_o), 64'h0);
    check("plan_rst_addr", 64'(rom_addr_o), 64'(RESET_PC));

    // random mix
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 4,
            $urandom_range(0, 11) == 0, $urandom,
            $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 59) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
